// File: rtl/cam_stream_gen.sv
// rtl/cam_stream_gen.sv - RGB444 camera pixel-stream generator with vsync/href framing.
// Optional CAM_STREAM_GEN_FRAME_CNT_EN adds frame_cnt and folds it into the ramp pattern.
module cam_stream_gen #(
  parameter int H_PIX   = 160,
  parameter int V_LINES = 120,
  parameter int VSYNC_W = 3,
  parameter int VBP     = 10,
  parameter int HBLANK  = 16,
  parameter int VFP     = 10
) (
  input  logic        CAM_pclk,
  input  logic        rst,
  input  logic        start,
  input  logic        cont,
  input  logic [1:0]  pattern_sel,
  input  logic [11:0] solid_rgb,
  output logic [7:0]  CAM_px_data,
  output logic        CAM_vsync,
  output logic        CAM_href,
  output logic        busy,
`ifdef CAM_STREAM_GEN_FRAME_CNT_EN
  output logic [7:0]  frame_cnt,
`endif
  output logic        frame_done
);

  localparam int XW = $clog2(H_PIX);
  localparam int YW = $clog2(V_LINES);
  localparam int CW = $clog2(2*H_PIX + VSYNC_W + VBP + HBLANK + VFP);

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBP, S_LINE, S_HBLANK, S_VFP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [XW-1:0] x, nx, bar_idx;
  logic [YW-1:0] y, ny;
  logic          odd, nodd;
  logic [1:0]    pat_q;
  logic [11:0]   rgb_q, rgb;
  logic [7:0]    nbyte;
  logic [3:0]    ramp_b;

`ifndef CAM_STREAM_GEN_FRAME_CNT_EN
  logic [7:0]    frame_cnt;
`endif

  // Outputs are registered, so the byte is computed for the position the next cycle will show.
  always_comb begin
    nx   = '0;
    ny   = '0;
    nodd = 1'b0;
    if (state == S_LINE) begin
      nodd = ~odd;
      nx   = odd ? x + 1'b1 : x;
      ny   = y;
    end else if (state == S_HBLANK) begin
      ny = y + 1'b1;
    end
    bar_idx = nx / XW'(H_PIX/8);
`ifdef CAM_STREAM_GEN_FRAME_CNT_EN
    ramp_b = nx[3:0] + ny[3:0] + frame_cnt[3:0];
`else
    ramp_b = nx[3:0] + ny[3:0];
`endif
    case (pat_q)
      2'd1: begin
        case (bar_idx)
          XW'(0):  rgb = 12'hFFF;
          XW'(1):  rgb = 12'hFF0;
          XW'(2):  rgb = 12'h0FF;
          XW'(3):  rgb = 12'h0F0;
          XW'(4):  rgb = 12'hF0F;
          XW'(5):  rgb = 12'hF00;
          XW'(6):  rgb = 12'h00F;
          default: rgb = 12'h000;
        endcase
      end
      2'd2:    rgb = {nx[3:0], ny[3:0], ramp_b};
      default: rgb = rgb_q;
    endcase
    nbyte = nodd ? rgb[7:0] : {4'h0, rgb[11:8]};
  end

  always_ff @(posedge CAM_pclk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      x           <= '0;
      y           <= '0;
      odd         <= 1'b0;
      pat_q       <= 2'd0;
      rgb_q       <= 12'h000;
      CAM_px_data <= 8'h00;
      CAM_vsync   <= 1'b0;
      CAM_href    <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= 8'h00;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_VSYNC;
            cnt       <= '0;
            pat_q     <= pattern_sel;
            rgb_q     <= solid_rgb;
            CAM_vsync <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_VSYNC: begin
          if (cnt == CW'(VSYNC_W-1)) begin
            state     <= S_VBP;
            cnt       <= '0;
            CAM_vsync <= 1'b0;
          end else cnt <= cnt + 1'b1;
        end
        S_VBP: begin
          if (cnt == CW'(VBP-1)) begin
            state       <= S_LINE;
            cnt         <= '0;
            CAM_href    <= 1'b1;
            CAM_px_data <= nbyte;
          end else cnt <= cnt + 1'b1;
        end
        S_LINE: begin
          if (cnt == CW'(2*H_PIX-1)) begin
            state       <= S_HBLANK;
            cnt         <= '0;
            x           <= '0;
            odd         <= 1'b0;
            CAM_href    <= 1'b0;
            CAM_px_data <= 8'h00;
          end else begin
            cnt         <= cnt + 1'b1;
            x           <= nx;
            odd         <= nodd;
            CAM_px_data <= nbyte;
          end
        end
        S_HBLANK: begin
          if (cnt == CW'(HBLANK-1)) begin
            cnt <= '0;
            if (y == YW'(V_LINES-1)) begin
              state <= S_VFP;
              y     <= '0;
            end else begin
              state       <= S_LINE;
              y           <= ny;
              CAM_href    <= 1'b1;
              CAM_px_data <= nbyte;
            end
          end else cnt <= cnt + 1'b1;
        end
        S_VFP: begin
          // frame_done is registered, so it is raised on the edge entering the last VFP cycle.
          if (cnt == CW'(VFP-2)) begin
            cnt        <= cnt + 1'b1;
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 1'b1;
          end else if (cnt == CW'(VFP-1)) begin
            cnt <= '0;
            if (cont) begin
              state     <= S_VSYNC;
              pat_q     <= pattern_sel;
              rgb_q     <= solid_rgb;
              CAM_vsync <= 1'b1;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else cnt <= cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_stream_gen.sv
// tb/tb_cam_stream_gen.sv - directed self-checking bench for cam_stream_gen.
module tb_cam_stream_gen;

  localparam int FRAME      = 40343;
  localparam int LINE_START = 13;
  localparam int VFP_START  = 40333;

  logic        CAM_pclk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [11:0] solid_rgb = 12'h000;
  logic [7:0]  CAM_px_data;
  logic        CAM_vsync;
  logic        CAM_href;
  logic        busy;
  logic        frame_done;
`ifdef CAM_STREAM_GEN_FRAME_CNT_EN
  logic [7:0]  frame_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] line_buf [320];

  cam_stream_gen dut (
    .CAM_pclk   (CAM_pclk),
    .rst        (rst),
    .start      (start),
    .cont       (cont),
    .pattern_sel(pattern_sel),
    .solid_rgb  (solid_rgb),
    .CAM_px_data(CAM_px_data),
    .CAM_vsync  (CAM_vsync),
    .CAM_href   (CAM_href),
    .busy       (busy),
`ifdef CAM_STREAM_GEN_FRAME_CNT_EN
    .frame_cnt  (frame_cnt),
`endif
    .frame_done (frame_done)
  );

  always #5 CAM_pclk = ~CAM_pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] exp_rgb(input logic [1:0] pat, input logic [11:0] solid,
                                          input int xx, input int yy, input logic [7:0] fc);
    logic [3:0] xs, ys, bs;
    xs = xx[3:0];
    ys = yy[3:0];
    bs = xs + ys;
`ifdef CAM_STREAM_GEN_FRAME_CNT_EN
    bs = bs + fc[3:0];
`else
    bs = bs + (fc[3:0] & 4'h0);
`endif
    case (pat)
      2'd1: begin
        case (xx / 20)
          0: return 12'hFFF;
          1: return 12'hFF0;
          2: return 12'h0FF;
          3: return 12'h0F0;
          4: return 12'hF0F;
          5: return 12'hF00;
          6: return 12'h00F;
          default: return 12'h000;
        endcase
      end
      2'd2:    return {xs, ys, bs};
      default: return solid;
    endcase
  endfunction

  // Walks one frame cycle by cycle from the first vsync cycle, comparing against the frame timeline.
  task automatic run_frame(input int n, input logic [1:0] pat, input logic [11:0] solid,
                           input logic [7:0] fc, input int spot_line, input int chg_at,
                           input logic [1:0] chg_pat, input logic chg_cont);
    int vs_err, hr_err, px_err, fd_err, busy_err, ov_err, href_hi;
    logic       e_vs, e_hr, e_fd;
    logic [7:0] e_px;
    logic [11:0] c;
    int u, ln, off;
    vs_err = 0; hr_err = 0; px_err = 0; fd_err = 0; busy_err = 0; ov_err = 0; href_hi = 0;
    for (int t = 0; t < n; t++) begin
      @(negedge CAM_pclk);
      e_vs = (t < 3);
      e_hr = 1'b0;
      e_px = 8'h00;
      e_fd = (t == FRAME - 1);
      if (t >= LINE_START && t < VFP_START) begin
        u   = t - LINE_START;
        ln  = u / 336;
        off = u % 336;
        if (off < 320) begin
          e_hr = 1'b1;
          c    = exp_rgb(pat, solid, off / 2, ln, fc);
          e_px = (off % 2 == 1) ? c[7:0] : {4'h0, c[11:8]};
          if (ln == spot_line) line_buf[off] = CAM_px_data;
        end
      end
      if (CAM_vsync !== e_vs) vs_err++;
      if (CAM_href !== e_hr) hr_err++;
      if (CAM_px_data !== e_px) px_err++;
      if (frame_done !== e_fd) fd_err++;
      if (busy !== 1'b1) busy_err++;
      if (CAM_vsync && CAM_href) ov_err++;
      if (CAM_href === 1'b1) href_hi++;
`ifdef CAM_STREAM_GEN_FRAME_CNT_EN
      if (t == FRAME - 1) check("frame_cnt", {24'h0, frame_cnt}, {24'h0, fc + 8'd1});
`endif
      if (t == 0) start = 1'b0;
      if (t == chg_at) begin
        pattern_sel = chg_pat;
        cont        = chg_cont;
        solid_rgb   = 12'h3C7;
      end
    end
    check("vsync_timeline", vs_err, 0);
    check("href_timeline", hr_err, 0);
    check("px_data", px_err, 0);
    check("frame_done", fd_err, 0);
    check("busy_in_frame", busy_err, 0);
    check("vsync_href_overlap", ov_err, 0);
    if (n == FRAME) check("href_cycles", href_hi, 38400);
  endtask

  task automatic idle_cycles(input int n, input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge CAM_pclk);
      if (busy || CAM_vsync || CAM_href || frame_done || (CAM_px_data != 8'h00)) bad++;
    end
    check(tag, bad, 0);
  endtask

  initial begin
    #1;
    check("reset_outputs", {busy, CAM_vsync, CAM_href, frame_done, CAM_px_data}, 12'h000);
    repeat (2) @(negedge CAM_pclk);
    rst = 1'b0;
    idle_cycles(4, "idle_after_reset");

    // Single solid frame; solid_rgb changes mid-frame must not show until the next frame.
    pattern_sel = 2'd0;
    solid_rgb   = 12'hA5C;
    cont        = 1'b0;
    start       = 1'b1;
    run_frame(FRAME, 2'd0, 12'hA5C, 8'd0, -1, 30000, 2'd0, 1'b0);
    idle_cycles(8, "idle_after_single_frame");

    // Colour bars free-running; pattern switched to ramp mid-frame.
    pattern_sel = 2'd1;
    cont        = 1'b1;
    start       = 1'b1;
    run_frame(FRAME, 2'd1, 12'h000, 8'd1, 0, 20000, 2'd2, 1'b1);
    check("bars_px0_b0", line_buf[0], 8'h0F);
    check("bars_px0_b1", line_buf[1], 8'hFF);
    check("bars_px20_b0", line_buf[40], 8'h0F);
    check("bars_px20_b1", line_buf[41], 8'hF0);
    check("bars_px159_b0", line_buf[318], 8'h00);
    check("bars_px159_b1", line_buf[319], 8'h00);

    // Back-to-back ramp frame, cut short by reset at line 60 byte 101.
    run_frame(LINE_START + 60*336 + 102, 2'd2, 12'h3C7, 8'd2, 5, 100, 2'd2, 1'b0);
    check("ramp_x17_y5_b0", line_buf[34], 8'h01);
`ifdef CAM_STREAM_GEN_FRAME_CNT_EN
    check("ramp_x17_y5_b1", line_buf[35], 8'h58);
`else
    check("ramp_x17_y5_b1", line_buf[35], 8'h56);
`endif
    check("pre_reset_href", CAM_href, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs", {busy, CAM_vsync, CAM_href, frame_done, CAM_px_data}, 12'h000);
`ifdef CAM_STREAM_GEN_FRAME_CNT_EN
    check("async_reset_frame_cnt", frame_cnt, 8'h00);
`endif
    repeat (2) @(negedge CAM_pclk);
    rst = 1'b0;
    idle_cycles(50, "idle_after_abort");

    start = 1'b1;
    @(negedge CAM_pclk);
    start = 1'b0;
    check("restart_vsync", {CAM_vsync, busy}, 2'b11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cam_stream_gen.md
Name: cam_stream_gen

Overview:
- Camera-side transmitter: emulates the sensor's parallel pixel interface for simulation and for board bring-up without a sensor.
- Emits RGB444 frames as two bytes per pixel, with CAM_vsync and CAM_href framing.
- Output feeds the capture block directly: same CAM_px_data/CAM_vsync/CAM_href signals, same 160x120 frame, same byte order.
- Pixel content comes from an internal pattern generator selected at run time.

Parameters:
- H_PIX, 160, pixels per line (two bytes each)
- V_LINES, 120, lines per frame (19200 pixels)
- VSYNC_W, 3, CAM_pclk cycles CAM_vsync held high
- VBP, 10, cycles between CAM_vsync falling and first CAM_href rising
- HBLANK, 16, cycles CAM_href low after every line, including the last
- VFP, 10, cycles after last HBLANK before frame end

Ports:
- CAM_pclk  input  1  pixel clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  sampled in IDLE; launches a frame
- cont  input  1  1 = free-running frames; 0 = single frame
- pattern_sel  input  2  0 solid, 1 colour bars, 2 ramp, 3 solid
- solid_rgb  input  12  RGB444 colour for solid pattern
- CAM_px_data  output  8  pixel byte
- CAM_vsync  output  1  frame sync, active high
- CAM_href  output  1  line valid, active high
- busy  output  1  high in any state other than IDLE
- frame_done  output  1  one-cycle pulse at end of each frame

Behaviour:
- Reset (async, any time, mid-frame included):
  - All outputs 0; FSM to IDLE; all counters 0.
  - The partially emitted frame is abandoned; no frame_done for it.
- All outputs are registered. The receiver samples them on the next rising edge.
- FSM states: IDLE, VSYNC, VBP, LINE, HBLANK, VFP.
  - IDLE: outputs low. start=1 at edge k → VSYNC from edge k.
  - On entry to VSYNC, latch pattern_sel and solid_rgb; they hold for the whole frame.
  - VSYNC: CAM_vsync=1 for VSYNC_W cycles → VBP.
  - VBP: VBP cycles with both syncs low → LINE, y=0.
  - LINE: CAM_href=1 for exactly 2*H_PIX cycles; byte phase toggles each cycle; x increments after each odd byte → HBLANK.
  - HBLANK: HBLANK cycles, CAM_href=0, CAM_px_data=0.
    - If y < V_LINES-1: y++, then LINE.
    - Otherwise: VFP.
  - VFP: VFP cycles. frame_done=1 during the last VFP cycle.
    - cont=1 sampled then → VSYNC; otherwise → IDLE.
    - cont and start are ignored outside IDLE/last VFP cycle.
- Total cycles per frame = VSYNC_W + VBP + V_LINES*(2*H_PIX + HBLANK) + VFP. Defaults give 40343.
- Byte order per pixel:
  - Even (first) byte = {4'b0000, R[3:0]}.
  - Odd byte = {G[3:0], B[3:0]}.
- CAM_px_data=0 whenever CAM_href=0.
- Patterns:
  - solid: solid_rgb.
  - bars: 8 bars, each H_PIX/8 wide, left to right FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - ramp: RGB = {x[3:0], y[3:0], (x+y)[3:0]}, sum truncated to 4 bits.
- Counters:
  - x width $clog2(H_PIX); y width $clog2(V_LINES).
  - Both wrap to 0 at line/frame end; no overflow beyond H_PIX-1 / V_LINES-1.
- CAM_vsync and CAM_href are never high in the same cycle.

Optional Feature:
- Macro: CAM_STREAM_GEN_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt[7:0]; reset 0.
  - Increments (wraps at 255) in the same cycle frame_done is asserted.
  - In ramp mode, the B nibble becomes (x+y+frame_cnt)[3:0], so consecutive frames differ.
- Undefined: no frame_cnt port; ramp as above.

Test Plan:
- Reset, start=1 one cycle, cont=0, pattern_sel=0, solid_rgb=12'hA5C → expected response:
  - CAM_vsync high 3 cycles, then 10 idle cycles.
  - 120 href windows of 320 cycles each; bytes alternate 0x0A, 0x5C.
  - frame_done single pulse at cycle 40343; then IDLE, busy=0.
- Colour bars → line 0 bytes:
  - px0 = 0x0F, 0xFF; px20 = 0x0F, 0xF0; px159 = 0x00, 0x00.
  - All 120 lines identical.
- Ramp, x=17, y=5 → bytes 0x01, 0x56.
- cont=1 → frames back to back:
  - Second CAM_vsync rises the cycle after the first frame_done.
  - pattern_sel changed mid-frame takes effect only in the next frame.
- rst asserted during line 60, byte 101 → expected response:
  - All outputs 0 immediately (asynchronously).
  - No frame_done; after release, stays IDLE until start.
- With CAM_STREAM_GEN_FRAME_CNT_EN, cont=1, 3 frames → frame_cnt 1, 2, 3 after each frame_done; ramp px(0,0) B nibble equals frame_cnt[3:0].
